uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Sequences the byte stream from the UART receiver into command frames for the
//  keyboard/display logic. Frame = HDR(0xA5), CMD, LEN, LEN payload bytes, CHK.
//  CHK = XOR of CMD, LEN and all payload bytes. Delivers each good frame on a
//  valid/ready port and reports framing errors. Sits between uart_rx and the consumers.
// PARAMETERS
//  MAX_LEN      4       max payload bytes per frame (1..16)
//  TIMEOUT_CYC  100000  inter-byte timeout in clk cycles (2 ms @ 50 MHz)
// PORTS
//  clk          in   1            system clock; the only clock in this block
//  rst          in   1            synchronous reset, active-high
//  rx_done      in   1            1-cycle pulse: rx_data is a new received byte
//  rx_data      in   8            received byte, valid only when rx_done=1
//  cmd_valid    out  1            frame available; held until it is accepted
//  cmd_ready    in   1            consumer accepts the frame when cmd_valid=1
//  cmd_code     out  8            CMD byte of the held frame
//  cmd_len      out  8            LEN byte of the held frame (0..MAX_LEN)
//  cmd_payload  out  8*MAX_LEN    payload byte i in bits [8i+7:8i]; unused bytes = 0
//  err_pulse    out  1            1-cycle error strobe
//  err_code     out  2            0=CHK mismatch 1=LEN>MAX_LEN 2=timeout 3=overflow
//  busy         out  1            1 in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, payload buffer and checksum cleared, timer cleared.
//  - FSM: IDLE -> CMD -> LEN -> PAY -> CHK -> HOLD -> IDLE. Moves only on rx_done.
//    IDLE: byte 0xA5 -> CMD. Any other byte is dropped silently with no error.
//    CMD: store code, chk<=byte, clear payload -> LEN.
//    LEN: byte>MAX_LEN -> err 1, IDLE. byte==0 -> CHK. Otherwise -> PAY. chk^=byte.
//    PAY: store at index idx, chk^=byte, idx++. After the LEN-th byte -> CHK.
//    CHK: byte==chk -> HOLD. Otherwise err 0, IDLE.
//  - Latency: cmd_valid rises in the cycle after the rx_done that carried the CHK byte.
//    cmd_code, cmd_len and cmd_payload are stable while cmd_valid=1.
//  - Handshake: a transfer occurs in the cycle with cmd_valid&&cmd_ready. In the next
//    cycle cmd_valid=0 and state is IDLE. cmd_ready has no effect outside HOLD.
//  - Handshake cycle coinciding with rx_done: the byte is evaluated as in IDLE
//    (0xA5 goes to CMD). This is not an overflow.
//  - HOLD with rx_done and no handshake: byte dropped, err 3, held frame untouched.
//  - Timeout: timer clears on every rx_done and counts in CMD/LEN/PAY/CHK.
//    At count TIMEOUT_CYC-1 with no rx_done: err 2, IDLE. rx_done in that same cycle
//    wins (byte processed, timer cleared). Timer does not run in IDLE or HOLD.
//  - err_pulse/err_code are registered and assert in the cycle after the causing
//    rx_done or timer event. err_code holds its last value when err_pulse=0.
//  - Widths: idx and LEN compares use $clog2(MAX_LEN+1) bits; timer uses
//    $clog2(TIMEOUT_CYC) bits.
//  - rst asserted mid-frame or in HOLD: the frame is discarded, no error is reported,
//    and the block returns to IDLE on the next clock.
// STRUCTURE
//  - uart_cmd_pkg: state enum (IDLE,CMD,LEN,PAY,CHK,HOLD), HDR_BYTE=8'hA5,
//    ERR_CHK/ERR_LEN/ERR_TMO/ERR_OVF codes.
//  - Sub-module uart_frame_timer: inter-byte timeout counter with clear/enable
//    inputs and an expire output.
//  - The top level holds the FSM, payload register file, checksum and output registers.
// TESTING
//  1 A5 01 02 12 34 25 with cmd_ready=1 -> one cmd_valid; code=01, len=02,
//    payload=0x00003412; err_pulse stays 0.
//  2 A5 01 02 12 34 26 -> err_pulse with code 0, no cmd_valid, busy=0 afterwards.
//  3 A5 09 05 -> err code 1 one cycle after the LEN byte; then A5 07 00 07 ->
//    cmd_valid with len=0 and payload=0.
//  4 A5 01, then no byte for TIMEOUT_CYC cycles -> err code 2 exactly at expiry,
//    state IDLE. Repeat with a byte arriving on the expiry cycle -> no error.
//  5 Good frame with cmd_ready=0, then byte A5 -> err code 3 and the held frame is
//    unchanged. Raise cmd_ready -> single transfer, then a new frame is accepted.
//  6 Assert rst after A5 01 02 12 -> all outputs 0 next cycle. Stray bytes 00 FF in
//    IDLE -> no error and busy=0.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAY,
    ST_CHK,
    ST_HOLD
  } state_e;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  localparam logic [1:0] ERR_CHK = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_OVF = 2'd3;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: runs while enabled, restarts on clr,
// and flags expire on its last count unless a byte arrives that cycle.
module uart_frame_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire = en && !clr && (cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (clr || !en || expire) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles HDR/CMD/LEN/payload/CHK byte frames from uart_rx into held
// commands on a valid/ready port, with a registered error strobe.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN     = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_done,
  input  logic [7:0]           rx_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_code,
  output logic [7:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_e                    state_q, state_d;
  logic [7:0]                code_q, code_d;
  logic [LW-1:0]             len_q, len_d;
  logic [LW-1:0]             idx_q, idx_d;
  logic [7:0]                chk_q, chk_d;
  logic [MAX_LEN-1:0][7:0]   pay_q, pay_d;
  logic                      err_pulse_q, err_pulse_d;
  logic [1:0]                err_code_q, err_code_d;
  logic                      tmr_en, tmr_expire;

  assign tmr_en = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                  (state_q == ST_PAY) || (state_q == ST_CHK);

  uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_done),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d     = state_q;
    code_d      = code_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    pay_d       = pay_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;

    unique case (state_q)
      ST_IDLE: if (rx_done && rx_data == HDR_BYTE) state_d = ST_CMD;
      ST_CMD: if (rx_done) begin
        code_d  = rx_data;
        chk_d   = rx_data;
        pay_d   = '0;
        idx_d   = '0;
        state_d = ST_LEN;
      end
      ST_LEN: if (rx_done) begin
        if (rx_data > 8'(MAX_LEN)) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_LEN;
          state_d     = ST_IDLE;
        end else begin
          len_d   = rx_data[LW-1:0];
          chk_d   = chk_q ^ rx_data;
          idx_d   = '0;
          state_d = (rx_data == 8'd0) ? ST_CHK : ST_PAY;
        end
      end
      ST_PAY: if (rx_done) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (idx_q == LW'(i)) pay_d[i] = rx_data;
        chk_d = chk_q ^ rx_data;
        idx_d = idx_q + LW'(1);
        if (idx_q + LW'(1) == len_q) state_d = ST_CHK;
      end
      ST_CHK: if (rx_done) begin
        if (rx_data == chk_q) begin
          state_d = ST_HOLD;
        end else begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_CHK;
          state_d     = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // A byte landing on the transfer cycle is treated as if already idle.
        if (cmd_ready) begin
          state_d = (rx_done && rx_data == HDR_BYTE) ? ST_CMD : ST_IDLE;
        end else if (rx_done) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_OVF;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmr_expire) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_TMO;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      // NOTE: the payload buffer is reset because it drives cmd_payload directly.
      pay_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      pay_q       <= pay_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_valid   = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign cmd_code    = code_q;
  assign cmd_len     = 8'(len_q);
  assign cmd_payload = pay_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench: directed frames plus random traffic, compared each
// cycle against a byte-list reference model of the frame protocol.
module tb_uart_cmd_ctrl;

  localparam int MAX_LEN = 4;
  localparam int TMO     = 64;

  logic                 clk;
  logic                 rst;
  logic                 rx_done;
  logic [7:0]           rx_data;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_code;
  logic [7:0]           cmd_len;
  logic [8*MAX_LEN-1:0] cmd_payload;
  logic                 err_pulse;
  logic [1:0]           err_code;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_cmd_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_code    (cmd_code),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: collects the bytes after the header in a list and
  // judges the frame once enough bytes have arrived.
  bit         m_in_frame, m_hold, m_ep;
  logic [7:0] m_bytes[$];
  int         m_idle;
  logic [7:0] m_code, m_len;
  logic [31:0] m_pay;
  logic [1:0] m_ec;

  function automatic void model_reset();
    m_in_frame = 0; m_hold = 0; m_ep = 0; m_bytes.delete(); m_idle = 0;
    m_code = 0; m_len = 0; m_pay = 0; m_ec = 0;
  endfunction

  function automatic void model_err(logic [1:0] code);
    m_ep = 1; m_ec = code; m_in_frame = 0;
  endfunction

  function automatic void model_start();
    m_in_frame = 1; m_bytes.delete(); m_idle = 0;
  endfunction

  function automatic void model_step(bit rx, logic [7:0] b, bit rdy);
    int n;
    logic [7:0] x;
    m_ep = 0;
    if (m_hold) begin
      if (rdy) begin
        m_hold = 0;
        if (rx && b == 8'hA5) model_start();
      end else if (rx) begin
        m_ep = 1; m_ec = 2'd3;
      end
    end else if (m_in_frame) begin
      if (rx) begin
        m_idle = 0;
        m_bytes.push_back(b);
        n = m_bytes.size();
        if (n == 2 && m_bytes[1] > MAX_LEN) begin
          model_err(2'd1);
        end else if (n >= 3 && n == int'(m_bytes[1]) + 3) begin
          x = 0;
          for (int i = 0; i < n - 1; i++) x ^= m_bytes[i];
          if (x == m_bytes[n-1]) begin
            m_hold = 1; m_in_frame = 0;
            m_code = m_bytes[0]; m_len = m_bytes[1]; m_pay = 0;
            for (int i = 0; i < int'(m_len); i++) m_pay[8*i +: 8] = m_bytes[2+i];
          end else begin
            model_err(2'd0);
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) model_err(2'd2);
      end
    end else if (rx && b == 8'hA5) begin
      model_start();
    end
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("cmd_valid", 32'(cmd_valid), 32'(m_hold));
    check("busy", 32'(busy), 32'(m_in_frame || m_hold));
    check("err_pulse", 32'(err_pulse), 32'(m_ep));
    check("err_code", 32'(err_code), 32'(m_ec));
    if (m_hold) begin
      check("cmd_code", 32'(cmd_code), 32'(m_code));
      check("cmd_len", 32'(cmd_len), 32'(m_len));
      check("cmd_payload", cmd_payload, m_pay);
    end
  endtask

  task automatic cycle(bit rx, logic [7:0] b, bit rdy);
    rx_done   = rx;
    rx_data   = rx ? b : 8'($urandom);
    cmd_ready = rdy;
    @(posedge clk);
    model_step(rx, b, rdy);
    @(negedge clk);
    compare_outputs();
    rx_done = 1'b0;
  endtask

  task automatic send(logic [7:0] b, bit rdy);
    cycle(1'b1, b, rdy);
  endtask

  task automatic gap(int n, bit rdy);
    repeat (n) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_done = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_code", 32'(cmd_code), 32'd0);
    check("rst_len", 32'(cmd_len), 32'd0);
    check("rst_payload", cmd_payload, 32'd0);
  endtask

  logic [7:0] fr[$];
  int kind, len, g;
  logic [7:0] x, code;

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: good frame, consumer ready
    send(8'hA5, 1); send(8'h01, 1); send(8'h02, 1); send(8'h12, 1); send(8'h34, 1);
    send(8'h25, 1);
    check("t1_valid", 32'(cmd_valid), 32'd1);
    check("t1_payload", cmd_payload, 32'h0000_3412);
    gap(2, 1);
    check("t1_no_valid_after", 32'(cmd_valid), 32'd0);

    // 2: bad checksum
    send(8'hA5, 1); send(8'h01, 1); send(8'h02, 1); send(8'h12, 1); send(8'h34, 1);
    send(8'h26, 1);
    check("t2_err_pulse", 32'(err_pulse), 32'd1);
    check("t2_err_code", 32'(err_code), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // 3: oversize LEN, then zero-length frame
    send(8'hA5, 1); send(8'h09, 1); send(8'h05, 1);
    check("t3_err_code", 32'(err_code), 32'd1);
    check("t3_err_pulse", 32'(err_pulse), 32'd1);
    send(8'hA5, 0); send(8'h07, 0); send(8'h00, 0); send(8'h07, 0);
    check("t3_len0_valid", 32'(cmd_valid), 32'd1);
    check("t3_len0_len", 32'(cmd_len), 32'd0);
    check("t3_len0_payload", cmd_payload, 32'd0);
    gap(1, 1);

    // 4: timeout exactly at expiry, then a byte on the expiry cycle
    send(8'hA5, 1); send(8'h01, 1);
    gap(TMO - 1, 1);
    check("t4_busy_before", 32'(busy), 32'd1);
    gap(1, 1);
    check("t4_tmo_pulse", 32'(err_pulse), 32'd1);
    check("t4_tmo_code", 32'(err_code), 32'd2);
    check("t4_tmo_idle", 32'(busy), 32'd0);
    send(8'hA5, 1); send(8'h01, 1);
    gap(TMO - 1, 1);
    send(8'h02, 1);
    check("t4_race_no_err", 32'(err_pulse), 32'd0);
    send(8'h12, 1); send(8'h34, 1); send(8'h25, 1);
    gap(1, 1);

    // 5: overflow while holding, then transfer and a new frame
    send(8'hA5, 0); send(8'h03, 0); send(8'h01, 0); send(8'h5A, 0); send(8'h58, 0);
    send(8'hA5, 0);
    check("t5_ovf_code", 32'(err_code), 32'd3);
    check("t5_held_payload", cmd_payload, 32'h0000_005A);
    gap(2, 0);
    gap(1, 1);
    check("t5_transferred", 32'(cmd_valid), 32'd0);
    send(8'hA5, 1); send(8'h04, 1); send(8'h01, 1); send(8'h10, 1); send(8'h15, 1);
    gap(1, 1);

    // 6: reset mid-frame, then stray bytes while idle
    send(8'hA5, 1); send(8'h01, 1); send(8'h02, 1); send(8'h12, 1);
    do_reset();
    send(8'h00, 1); send(8'hFF, 1);
    check("t6_stray_busy", 32'(busy), 32'd0);
    check("t6_stray_err", 32'(err_pulse), 32'd0);

    // Random traffic
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      fr.delete();
      kind = $urandom_range(0, 9);
      len  = $urandom_range(0, MAX_LEN);
      code = 8'($urandom);
      if (kind == 0) begin
        for (int i = 0; i <= len; i++) fr.push_back(8'($urandom));
      end else if (kind == 1) begin
        fr.push_back(8'hA5); fr.push_back(code);
        fr.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        fr.push_back(8'hA5); fr.push_back(code); fr.push_back(8'(len));
        x = code ^ 8'(len);
        for (int i = 0; i < len; i++) begin
          fr.push_back(8'($urandom));
          x ^= fr[fr.size()-1];
        end
        fr.push_back((kind == 2) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
        if (kind == 3) begin
          g = $urandom_range(1, fr.size() - 1);
          repeat (g) void'(fr.pop_back());
        end
      end
      foreach (fr[i]) begin
        send(fr[i], $urandom_range(0, 3) != 0);
        g = ($urandom_range(0, 19) == 0) ? (TMO - 1 + $urandom_range(0, 1))
                                         : $urandom_range(0, 2);
        gap(g, $urandom_range(0, 3) != 0);
      end
      if (kind == 3) gap(TMO + 2, 1);
    end
    gap(4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
